// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings,
// FSM state type and the access-size helpers used by the datapath and FSM.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    RMW_WR  = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Access size from funct3; the undefined encodings fall back to a word.
  function automatic lsu_size_t f3_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  // Halfwords need an even address, words a multiple of four.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (f3_size(funct3))
      SZ_H:    return lane[0];
      SZ_W:    return (lane != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational byte-lane logic shared by the load and store paths:
// extracts and sign/zero-extends a load from the RAM word, and merges store
// data into the RAM word for sub-word read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_ram_q,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  lsu_size_t   w_size;
  logic        w_unsigned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_size     = f3_size(i_funct3);
  assign w_unsigned = i_funct3[2];
  assign w_byte     = i_ram_q[{i_lane, 3'b000} +: 8];
  assign w_half     = i_lane[1] ? i_ram_q[31:16] : i_ram_q[15:0];

  // Load path: pick the addressed byte/halfword and extend it to a full word.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves the output unassigned (latch).
    o_load = i_ram_q;
    case (w_size)
      SZ_B:    o_load = {{24{w_byte[7] & ~w_unsigned}}, w_byte};
      SZ_H:    o_load = {{16{w_half[15] & ~w_unsigned}}, w_half};
      default: o_load = i_ram_q;
    endcase
  end

  // Store path: overwrite only the addressed lane(s) of the current RAM word.
  always_comb begin
    o_merge = i_ram_q;
    case (w_size)
      SZ_B: o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      SZ_H: begin
        if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
        else           o_merge[15:0]  = i_wdata[15:0];
      end
      default: o_merge = i_wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit between the core and a word-wide synchronous-read data RAM.
// Loads take two cycles (address, then extract); word stores take one cycle;
// byte/halfword stores take two (read, then merged write-back). The core is
// stalled during the first cycle of any multi-cycle access.
// Optional build macro LSU_PERF_CNT_EN adds load/store/stall event counters.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ_READ,
  input  logic                  REQ_WRITE,
  input  logic [2:0]            FUNCT3,
  input  logic [SIZE-1:0]       ADDR,
  input  logic [SIZE-1:0]       WDATA,
  output logic [SIZE-1:0]       RDATA,
  output logic                  STALL,
  output logic                  MISALIGNED,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  input  logic [SIZE-1:0]       RAM_Q,
  output logic [SIZE-1:0]       RAM_D,
  output logic                  RAM_WE
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]           LOAD_CNT,
  output logic [31:0]           STORE_CNT,
  output logic [31:0]           STALL_CNT
`endif
);

  lsu_state_t      r_state;
  lsu_state_t      w_next_state;
  logic [1:0]      w_lane;
  logic            w_misaligned;
  logic [SIZE-1:0] w_load;
  logic [SIZE-1:0] w_merge;
  logic            w_unused_addr;

  // Upper address bits fall outside the RAM, so word addresses wrap.
  assign RAM_ADDR      = ADDR[ADDR_WIDTH+1:2];
  assign w_lane        = ADDR[1:0];
  assign w_misaligned  = is_misaligned(FUNCT3, w_lane);
  assign w_unused_addr = ^ADDR[SIZE-1:ADDR_WIDTH+2];

  lsu_align u_align (
    .i_ram_q  (RAM_Q),
    .i_wdata  (WDATA),
    .i_lane   (w_lane),
    .i_funct3 (FUNCT3),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  // State register; any reset abandons an in-flight access.
  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next state and outputs; everything is held idle while reset is asserted.
  always_comb begin
    w_next_state = r_state;
    STALL        = 1'b0;
    MISALIGNED   = 1'b0;
    RAM_WE       = 1'b0;
    RAM_D        = '0;
    RDATA        = '0;
    if (RESET_N) begin
      case (r_state)
        IDLE: begin
          // A read wins over a simultaneous write.
          if (REQ_READ) begin
            if (w_misaligned) begin
              MISALIGNED = 1'b1;
            end else begin
              STALL        = 1'b1;
              w_next_state = LD_WAIT;
            end
          end else if (REQ_WRITE) begin
            if (w_misaligned) begin
              MISALIGNED = 1'b1;
            end else if (f3_size(FUNCT3) == SZ_W) begin
              RAM_WE = 1'b1;
              RAM_D  = WDATA;
            end else begin
              STALL        = 1'b1;
              w_next_state = RMW_WR;
            end
          end
        end
        LD_WAIT: begin
          RDATA        = w_load;
          w_next_state = IDLE;
        end
        RMW_WR: begin
          RAM_D        = w_merge;
          RAM_WE       = 1'b1;
          w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  // Event counters: completed loads, completed stores and stalled cycles.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      LOAD_CNT  <= '0;
      STORE_CNT <= '0;
      STALL_CNT <= '0;
    end else begin
      if (r_state == LD_WAIT) LOAD_CNT  <= LOAD_CNT + 32'd1;
      if (RAM_WE)             STORE_CNT <= STORE_CNT + 32'd1;
      if (STALL)              STALL_CNT <= STALL_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed vector table from the
// reference scenarios, a mid-operation reset sequence, then randomized
// accesses checked against an arithmetic reference model of the RAM.
`timescale 1ns/1ps
module tb_data_mem_lsu;
  import lsu_pkg::*;

  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          REQ_READ, REQ_WRITE;
  logic [2:0]    FUNCT3;
  logic [31:0]   ADDR, WDATA, RDATA;
  logic          STALL, MISALIGNED;
  logic [AW-1:0] RAM_ADDR;
  logic [31:0]   RAM_Q, RAM_D;
  logic          RAM_WE;
`ifdef LSU_PERF_CNT_EN
  logic [31:0]   LOAD_CNT, STORE_CNT, STALL_CNT;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int unsigned m_ld = 0, m_st = 0, m_stall = 0;

  always #5 CLK = ~CLK;

  data_mem_lsu #(.SIZE(32), .ADDR_WIDTH(AW)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .REQ_READ   (REQ_READ),
    .REQ_WRITE  (REQ_WRITE),
    .FUNCT3     (FUNCT3),
    .ADDR       (ADDR),
    .WDATA      (WDATA),
    .RDATA      (RDATA),
    .STALL      (STALL),
    .MISALIGNED (MISALIGNED),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_Q      (RAM_Q),
    .RAM_D      (RAM_D),
    .RAM_WE     (RAM_WE)
`ifdef LSU_PERF_CNT_EN
    ,
    .LOAD_CNT   (LOAD_CNT),
    .STORE_CNT  (STORE_CNT),
    .STALL_CNT  (STALL_CNT)
`endif
  );

  // Synchronous-read RAM with a backdoor preload port.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;

  always @(posedge CLK) begin
    if (pl_en)       mem[pl_addr]  <= pl_data;
    else if (RAM_WE) mem[RAM_ADDR] <= RAM_D;
    RAM_Q <= mem[RAM_ADDR];
  end

  // Reference contents of the 16 words the test touches.
  logic [31:0] ref_mem [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % size_bytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [2:0] f3);
    longint unsigned mask, v;
    int sh;
    mask = (64'd1 << (8 * size_bytes(f3))) - 64'd1;
    sh   = 8 * int'(addr % 4);
    v    = (64'(word) >> sh) & mask;
    if (!f3[2] && size_bytes(f3) < 4 && v > (mask >> 1)) v = v - (mask + 64'd1);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] wdata,
                                            input logic [31:0] addr, input logic [2:0] f3);
    longint unsigned mask, v;
    int sh;
    mask = (64'd1 << (8 * size_bytes(f3))) - 64'd1;
    sh   = 8 * int'(addr % 4);
    v    = (64'(word) & ~(mask << sh)) | ((64'(wdata) & mask) << sh);
    return v[31:0];
  endfunction

  // Drives one access at a negedge and checks every cycle of it; exp is the
  // final RDATA for loads or the RAM_D written for stores.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, input string nm);
    logic [31:0] wa;
    wa = (addr >> 2) % (1 << AW);
    @(negedge CLK);
    REQ_READ = rd; REQ_WRITE = wr; FUNCT3 = f3; ADDR = addr; WDATA = wd;
    #1;
    check({nm, "_ram_addr"}, 32'(RAM_ADDR), wa);
    if (!rd && !wr) begin
      check({nm, "_idle_flags"}, {29'd0, STALL, RAM_WE, MISALIGNED}, 32'd0);
      check({nm, "_idle_rdata"}, RDATA, 32'd0);
    end else if (ref_misaligned(f3, addr)) begin
      check({nm, "_mis_flags"}, {29'd0, STALL, RAM_WE, MISALIGNED}, 32'b001);
      check({nm, "_mis_rdata"}, RDATA, 32'd0);
    end else if (rd) begin
      check({nm, "_ld1_flags"}, {29'd0, STALL, RAM_WE, MISALIGNED}, 32'b100);
      @(negedge CLK); #1;
      check({nm, "_ld2_flags"}, {29'd0, STALL, RAM_WE, MISALIGNED}, 32'b000);
      check({nm, "_rdata"}, RDATA, exp);
      m_ld++; m_stall++;
    end else if (size_bytes(f3) == 4) begin
      check({nm, "_sw_flags"}, {29'd0, STALL, RAM_WE, MISALIGNED}, 32'b010);
      check({nm, "_sw_ram_d"}, RAM_D, exp);
      ref_mem[wa % 16] = ref_store(ref_mem[wa % 16], wd, addr, f3);
      m_st++;
    end else begin
      check({nm, "_rmw1_flags"}, {29'd0, STALL, RAM_WE, MISALIGNED}, 32'b100);
      @(negedge CLK); #1;
      check({nm, "_rmw2_flags"}, {29'd0, STALL, RAM_WE, MISALIGNED}, 32'b010);
      check({nm, "_rmw_addr"}, 32'(RAM_ADDR), wa);
      check({nm, "_rmw_ram_d"}, RAM_D, exp);
      ref_mem[wa % 16] = ref_store(ref_mem[wa % 16], wd, addr, f3);
      m_st++; m_stall++;
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, ex, wa;

    // Directed vectors; word 5 starts as 8899AABB.
    vecs[0]  = '{1'b1, 1'b0, F3_B,   32'h17,   32'h0,        32'hFFFFFF88, "lb_17"};
    vecs[1]  = '{1'b1, 1'b0, F3_BU,  32'h16,   32'h0,        32'h00000099, "lbu_16"};
    vecs[2]  = '{1'b1, 1'b0, F3_H,   32'h14,   32'h0,        32'hFFFFAABB, "lh_14"};
    vecs[3]  = '{1'b1, 1'b0, F3_HU,  32'h16,   32'h0,        32'h00008899, "lhu_16"};
    vecs[4]  = '{1'b0, 1'b1, F3_H,   32'h16,   32'hDEAD1234, 32'h1234AABB, "sh_16"};
    vecs[5]  = '{1'b1, 1'b0, F3_W,   32'h14,   32'h0,        32'h1234AABB, "lw_after_sh"};
    vecs[6]  = '{1'b0, 1'b1, F3_W,   32'h14,   32'hCAFEF00D, 32'hCAFEF00D, "sw_14"};
    vecs[7]  = '{1'b1, 1'b0, F3_W,   32'h14,   32'h0,        32'hCAFEF00D, "lw_after_sw"};
    vecs[8]  = '{1'b1, 1'b0, F3_W,   32'h15,   32'h0,        32'h0,        "lw_mis_15"};
    vecs[9]  = '{1'b0, 1'b1, F3_H,   32'h13,   32'h5555,     32'h0,        "sh_mis_13"};
    vecs[10] = '{1'b1, 1'b1, F3_B,   32'h14,   32'h77,       32'h0000000D, "rd_wr_prio"};
    vecs[11] = '{1'b1, 1'b0, F3_W,   32'h14,   32'h0,        32'hCAFEF00D, "lw_no_drop_wr"};
    vecs[12] = '{1'b1, 1'b0, F3_W,   32'h1014, 32'h0,        32'hCAFEF00D, "lw_wrap"};
    vecs[13] = '{1'b1, 1'b0, 3'b011, 32'h14,   32'h0,        32'hCAFEF00D, "undef_f3_ld"};
    vecs[14] = '{1'b1, 1'b0, 3'b111, 32'h16,   32'h0,        32'h0,        "undef_f3_mis"};
    vecs[15] = '{1'b0, 1'b1, F3_B,   32'h15,   32'h000000AB, 32'hCAFEAB0D, "sb_15"};
    vecs[16] = '{1'b1, 1'b0, F3_B,   32'h15,   32'h0,        32'hFFFFFFAB, "lb_15"};

    RESET_N = 1'b0; REQ_READ = 1'b0; REQ_WRITE = 1'b0;
    FUNCT3 = F3_W; ADDR = '0; WDATA = '0;

    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      pl_en   = 1'b1;
      pl_addr = AW'(i);
      pl_data = (i == 5) ? 32'h8899AABB : $urandom;
      ref_mem[i] = pl_data;
    end
    @(negedge CLK);
    pl_en = 1'b0;

    // Reset state, also with a request pending on the inputs.
    #1;
    check("rst_flags", {29'd0, STALL, RAM_WE, MISALIGNED}, 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_ram_d", RAM_D, 32'd0);
    check("rst_ram_addr", 32'(RAM_ADDR), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    REQ_READ = 1'b1; ADDR = 32'h14; #1;
    check("rst_req_flags", {29'd0, STALL, RAM_WE, MISALIGNED}, 32'd0);
    REQ_READ = 1'b0; ADDR = '0;
`ifdef LSU_PERF_CNT_EN
    check("rst_cnts", LOAD_CNT | STORE_CNT | STALL_CNT, 32'd0);
`endif
    @(negedge CLK);
    RESET_N = 1'b1;

    run_op(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 32'h0, "idle0");
    for (int i = 0; i < 17; i++)
      run_op(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp, vecs[i].nm);

    // Reset while the sub-word store is in its write-back cycle.
    @(negedge CLK);
    REQ_READ = 1'b0; REQ_WRITE = 1'b1; FUNCT3 = F3_B; ADDR = 32'h14; WDATA = 32'h55;
    #1;
    check("midrst_stall", {31'd0, STALL}, 32'd1);
    @(posedge CLK); #1;
    check("midrst_in_rmw", 32'(dut.r_state), 32'(RMW_WR));
    RESET_N = 1'b0; #1;
    check("midrst_we", {31'd0, RAM_WE}, 32'd0);
    check("midrst_state", 32'(dut.r_state), 32'(IDLE));
    @(posedge CLK); #1;
    check("midrst_word5", mem[5], ref_mem[5]);
`ifdef LSU_PERF_CNT_EN
    check("midrst_cnts", LOAD_CNT | STORE_CNT | STALL_CNT, 32'd0);
`endif
    m_ld = 0; m_st = 0; m_stall = 0;
    @(negedge CLK);
    REQ_WRITE = 1'b0;
    RESET_N   = 1'b1;
    run_op(1'b1, 1'b0, F3_W, 32'h14, 32'h0, ref_mem[5], "lw_after_midrst");

    // Randomized accesses over words 0..15 with random upper address bits.
    for (int n = 0; n < 300; n++) begin
      rd   = 1'($urandom % 2);
      wr   = 1'($urandom % 2);
      f3   = 3'($urandom % 8);
      if (!rd && f3[2:1] == 2'b10) f3[2] = 1'b0;
      addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      wd   = $urandom;
      wa   = (addr >> 2) % 16;
      if (rd) ex = ref_load(ref_mem[wa], addr, f3);
      else    ex = ref_store(ref_mem[wa], wd, addr, f3);
      run_op(rd, wr, f3, addr, wd, ex, "rand");
    end
    @(negedge CLK);
    REQ_READ = 1'b0; REQ_WRITE = 1'b0;
    @(negedge CLK);

`ifdef LSU_PERF_CNT_EN
    check("load_cnt", LOAD_CNT, m_ld);
    check("store_cnt", STORE_CNT, m_st);
    check("stall_cnt", STALL_CNT, m_stall);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
